// File: rtl/filtro_pkg.sv
// -----------------------------------------------------------------------------
// filtro_pkg
// Shared definitions for the fk filter datapath.
//   N_DEF, F_DEF   : default sample width and fractional bits (Q(N-F).F)
//   state_t        : MAC sequencer states
//   sat_max/sat_min: saturation limits of an n-bit two's complement value
//   SAT_MAX_DEF/SAT_MIN_DEF : those limits for the default width
// -----------------------------------------------------------------------------
package filtro_pkg;

  localparam int N_DEF = 25;
  localparam int F_DEF = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MAC0 = 3'd1,
    MAC1 = 3'd2,
    MAC2 = 3'd3,
    SAT  = 3'd4
  } state_t;

  // Largest value representable in n-bit two's complement.
  function automatic longint sat_max(input int n);
    return (longint'(1) << (n - 1)) - 1;
  endfunction

  // Smallest value representable in n-bit two's complement.
  function automatic longint sat_min(input int n);
    return -(longint'(1) << (n - 1));
  endfunction

  localparam longint SAT_MAX_DEF = sat_max(N_DEF);
  localparam longint SAT_MIN_DEF = sat_min(N_DEF);

endpackage

// File: rtl/sat_fk.sv
// -----------------------------------------------------------------------------
// sat_fk
// Combinational scale / round / saturate from the 2N+2-bit accumulator down
// to an N-bit Q(N-F).F sample.
//   acc      in  2N+2  signed accumulator
//   y_next   out N     scaled and clamped result
//   ovf_next out 1     high when the result was clamped
// Build option MAC_FILTRO_REDONDEO_EN: add half an LSB before the shift
// (round half up); otherwise the shift truncates toward minus infinity.
// -----------------------------------------------------------------------------
module sat_fk
  import filtro_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int F = F_DEF
) (
  input  logic [2*N+1:0] acc,
  output logic [N-1:0]   y_next,
  output logic           ovf_next
);

  localparam int AW = 2 * N + 2;
  localparam logic signed [AW-1:0] MAXV = AW'(sat_max(N));
  localparam logic signed [AW-1:0] MINV = AW'(sat_min(N));

  logic signed [AW-1:0] rounded;
  logic signed [AW-1:0] scaled;

`ifdef MAC_FILTRO_REDONDEO_EN
  localparam logic signed [AW-1:0] HALF = AW'(longint'(1) << (F - 1));
  // Headroom of the accumulator guarantees this addition cannot wrap.
  assign rounded = $signed(acc) + HALF;
`else
  assign rounded = $signed(acc);
`endif

  assign scaled = rounded >>> F;

  // Clamp anything that does not fit in N bits after scaling.
  always_comb begin
    y_next   = scaled[N-1:0];
    ovf_next = 1'b0;
    if (scaled > MAXV) begin
      y_next   = MAXV[N-1:0];
      ovf_next = 1'b1;
    end else if (scaled < MINV) begin
      y_next   = MINV[N-1:0];
      ovf_next = 1'b1;
    end
  end

endmodule

// File: rtl/mac_filtro_fk.sv
// -----------------------------------------------------------------------------
// mac_filtro_fk
// Three-tap multiply-accumulate y = b0*fk + b1*fk_1 + b2*fk_2 using a single
// shared multiplier over three cycles, followed by scale and saturation.
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle request; ignored while busy
//   fk, fk_1, fk_2      samples (signed N bits), snapshotted on accept
//   b0, b1, b2          coefficients (signed N bits), snapshotted on accept
//   y                   saturated result, held between done pulses
//   done                one-cycle strobe when y is updated
//   busy                computation in flight
//   ovf                 result was clamped (meaningful with done)
// Build option MAC_FILTRO_REDONDEO_EN selects round-half-up scaling in sat_fk.
// -----------------------------------------------------------------------------
module mac_filtro_fk
  import filtro_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int F = F_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] fk,
  input  logic [N-1:0] fk_1,
  input  logic [N-1:0] fk_2,
  input  logic [N-1:0] b0,
  input  logic [N-1:0] b1,
  input  logic [N-1:0] b2,
  output logic [N-1:0] y,
  output logic         done,
  output logic         busy,
  output logic         ovf
);

  localparam int AW = 2 * N + 2;

  state_t state, next_state;

  logic [N-1:0]          op_f0, op_f1, op_f2;
  logic [N-1:0]          op_b0, op_b1, op_b2;
  logic signed [AW-1:0]  acc;
  logic signed [N-1:0]   mul_a, mul_b;
  logic signed [2*N-1:0] prod;
  logic [N-1:0]          y_next;
  logic                  ovf_next;

  // Sequencer: one tap per MAC state, then one cycle to publish the result.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = MAC0;
      MAC0:    next_state = MAC1;
      MAC1:    next_state = MAC2;
      MAC2:    next_state = SAT;
      SAT:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand select for the shared multiplier.
  always_comb begin
    mul_a = $signed(op_f0);
    mul_b = $signed(op_b0);
    case (state)
      MAC1: begin
        mul_a = $signed(op_f1);
        mul_b = $signed(op_b1);
      end
      MAC2: begin
        mul_a = $signed(op_f2);
        mul_b = $signed(op_b2);
      end
      default: ;
    endcase
  end

  assign prod = mul_a * mul_b;

  sat_fk #(.N(N), .F(F)) u_sat (
    .acc      (acc),
    .y_next   (y_next),
    .ovf_next (ovf_next)
  );

  // State, operand snapshot, accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_f0 <= '0;
      op_f1 <= '0;
      op_f2 <= '0;
      op_b0 <= '0;
      op_b1 <= '0;
      op_b2 <= '0;
      acc   <= '0;
      y     <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= next_state;
      done  <= 1'b0;
      busy  <= (next_state != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            op_f0 <= fk;
            op_f1 <= fk_1;
            op_f2 <= fk_2;
            op_b0 <= b0;
            op_b1 <= b1;
            op_b2 <= b2;
            acc   <= '0;
          end
        end
        MAC0, MAC1, MAC2: begin
          acc <= acc + {{2{prod[2*N-1]}}, prod};
        end
        SAT: begin
          y    <= y_next;
          ovf  <= ovf_next;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_filtro_fk.sv
// -----------------------------------------------------------------------------
// tb_mac_filtro_fk
// Directed bench for mac_filtro_fk with hand-computed expected results.
// Expected rounding results follow MAC_FILTRO_REDONDEO_EN when defined.
// -----------------------------------------------------------------------------
module tb_mac_filtro_fk;

  localparam int N = 25;

  localparam longint Y_NOM  = 24576;
  localparam longint Y_PMAX = 16777215;
  localparam longint Y_NMIN = -16777216;

`ifdef MAC_FILTRO_REDONDEO_EN
  localparam longint Y_RND_POS = 1;
  localparam longint Y_RND_NEG = 0;
`else
  localparam longint Y_RND_POS = 0;
  localparam longint Y_RND_NEG = -1;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] fk, fk_1, fk_2;
  logic [N-1:0] b0, b1, b2;
  logic [N-1:0] y;
  logic         done;
  logic         busy;
  logic         ovf;

  int checks;
  int passes;
  int lat;
  int ndone;

  mac_filtro_fk dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .fk    (fk),
    .fk_1  (fk_1),
    .fk_2  (fk_2),
    .b0    (b0),
    .b1    (b1),
    .b2    (b2),
    .y     (y),
    .done  (done),
    .busy  (busy),
    .ovf   (ovf)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed == expected) passes++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  // Drive operands and a one-cycle start; call at a negedge. Returns just
  // after the accepting edge.
  task automatic applyStimulus(input int vf0, input int vf1, input int vf2,
                               input int vb0, input int vb1, input int vb2);
    fk    = N'(vf0);
    fk_1  = N'(vf1);
    fk_2  = N'(vf2);
    b0    = N'(vb0);
    b1    = N'(vb1);
    b2    = N'(vb2);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Edges from the accepting edge to the edge that raised done; -1 on timeout.
  task automatic waitDone(output int cycles);
    cycles = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) break;
      cycles++;
    end
    if (!done) cycles = -1;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    fk = '0; fk_1 = '0; fk_2 = '0;
    b0 = '0; b1 = '0; b2 = '0;

    #12;
    checkOutput("reset_y",    longint'($signed(y)), 0);
    checkOutput("reset_done", longint'(done), 0);
    checkOutput("reset_busy", longint'(busy), 0);
    checkOutput("reset_ovf",  longint'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal: 2^31 + 2^29 - 2^30 = 1610612736, >>16 = 24576
    applyStimulus(65536, 32768, -16384, 32768, 16384, 65536);
    waitDone(lat);
    checkOutput("nom_latency", lat, 4);
    checkOutput("nom_y",   longint'($signed(y)), Y_NOM);
    checkOutput("nom_ovf", longint'(ovf), 0);
    @(negedge clk);
    checkOutput("nom_done_width", longint'(done), 0);

    // Positive saturation: 3 * 16777215 clamps high
    applyStimulus(16777215, 16777215, 16777215, 65536, 65536, 65536);
    waitDone(lat);
    checkOutput("psat_latency", lat, 4);
    checkOutput("psat_y",   longint'($signed(y)), Y_PMAX);
    checkOutput("psat_ovf", longint'(ovf), 1);

    // Negative saturation
    @(negedge clk);
    applyStimulus(-16777215, -16777215, -16777215, 65536, 65536, 65536);
    waitDone(lat);
    checkOutput("nsat_y",   longint'($signed(y)), Y_NMIN);
    checkOutput("nsat_ovf", longint'(ovf), 1);

    // Snapshot: operands changed after the accepting edge must not matter
    @(negedge clk);
    applyStimulus(65536, 32768, -16384, 32768, 16384, 65536);
    fk = N'(999);
    b0 = N'(-5000);
    waitDone(lat);
    checkOutput("snap_y",   longint'($signed(y)), Y_NOM);
    checkOutput("snap_ovf", longint'(ovf), 0);

    // Rounding boundary: +/- half an LSB
    @(negedge clk);
    applyStimulus(1, 0, 0, 32768, 0, 0);
    waitDone(lat);
    checkOutput("rnd_pos_y", longint'($signed(y)), Y_RND_POS);
    @(negedge clk);
    applyStimulus(-1, 0, 0, 32768, 0, 0);
    waitDone(lat);
    checkOutput("rnd_neg_y", longint'($signed(y)), Y_RND_NEG);

    // Busy rejection: starts at t+2 and t+4 are dropped
    @(negedge clk);
    applyStimulus(65536, 32768, -16384, 32768, 16384, 65536);
    @(negedge clk);
    checkOutput("busy_after_t", longint'(busy), 1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("busy_t3", longint'(busy), 1);
    checkOutput("early_done", longint'(done), 0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checkOutput("rej_done_t4", longint'(done), 1);
    checkOutput("rej_busy_t4", longint'(busy), 0);
    checkOutput("rej_y", longint'($signed(y)), Y_NOM);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checkOutput("rej_extra_done", ndone, 0);

    // Back-to-back: new start at t+5 completes at t+9
    applyStimulus(16777215, 16777215, 16777215, 65536, 65536, 65536);
    waitDone(lat);
    checkOutput("b2b_first_y", longint'($signed(y)), Y_PMAX);
    applyStimulus(65536, 32768, -16384, 32768, 16384, 65536);
    waitDone(lat);
    checkOutput("b2b_latency", lat, 4);
    checkOutput("b2b_y", longint'($signed(y)), Y_NOM);

    // Reset in the middle of a computation
    @(negedge clk);
    applyStimulus(16777215, 16777215, 16777215, 65536, 65536, 65536);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_y",    longint'($signed(y)), 0);
    checkOutput("mid_rst_busy", longint'(busy), 0);
    checkOutput("mid_rst_ovf",  longint'(ovf), 0);
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checkOutput("mid_rst_no_done", ndone, 0);
    applyStimulus(65536, 32768, -16384, 32768, 16384, 65536);
    waitDone(lat);
    checkOutput("post_rst_latency", lat, 4);
    checkOutput("post_rst_y", longint'($signed(y)), Y_NOM);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
